// File: rtl/lt24_lcd_rst_seq_if.sv
// Avalon-MM slave bus bundle for the LT24 LCD reset sequencer.
// Signals:
//   address    - word address (2 bits)
//   chipselect - chip select
//   write_n    - write strobe, active-low
//   writedata  - write data (32 bits)
//   readdata   - read data (32 bits), zero wait states
interface lt24_lcd_rst_seq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/lt24_lcd_rst_seq.sv
// Timed reset sequencer for the LT24 LCD panel.
// Takes the software reset-request level from the LCD reset PIO, enforces the
// panel's minimum reset-low time and post-release recovery time, drives the
// physical RSTN pin and reports readiness.
//
// Ports:
//   clk        - system clock
//   reset      - asynchronous active-high reset
//   rst_req_n  - reset-request level from the PIO (0 = hold panel in reset)
//   bus        - Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//                write address 1 with writedata[0]=1 : soft reset pulse
//                read  address 0 : {29'b0, lcd_ready, state}
//                read  address 2 : {24'b0, seq_count}
//   lcd_rstn   - registered LCD reset pin, active-low
//   lcd_ready  - registered, high only while the panel is ready
//
// Build option:
//   LT24_RST_SEQ_SYNC_EN - when defined, rst_req_n goes through a 2-flop
//                          synchronizer; leave undefined only when the PIO
//                          runs on clk.
module lt24_lcd_rst_seq #(
    parameter int unsigned LOW_CYCLES      = 500,
    parameter int unsigned RECOVERY_CYCLES = 6000000,
    parameter int unsigned CNT_W           = 23
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rst_req_n,
    lt24_lcd_rst_seq_if.slave       bus,
    output logic                    lcd_rstn,
    output logic                    lcd_ready
);

    localparam logic [CNT_W-1:0] LOW_LAST = CNT_W'(LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(RECOVERY_CYCLES - 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RECOVER = 2'd1,
        READY   = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [7:0]         seq_count;
    logic               seq_inc;
    logic               req;
    logic               soft_pulse;
    logic               unused_wdata;

    // Reset-request conditioning
`ifdef LT24_RST_SEQ_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], rst_req_n};
        end
    end

    assign req = sync_q[1];
`else
    assign req = rst_req_n;
`endif

    // Software-initiated reset pulse
    assign soft_pulse = bus.chipselect && !bus.write_n &&
                        (bus.address == 2'd1) && bus.writedata[0];

    assign unused_wdata = ^bus.writedata[31:1];

    // State, counter and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            seq_count <= 8'd0;
            lcd_rstn  <= 1'b0;
            lcd_ready <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            if (seq_inc) begin
                seq_count <= seq_count + 8'd1;
            end
            lcd_rstn  <= (state_d != HOLD);
            lcd_ready <= (state_d == READY);
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seq_inc = 1'b0;

        case (state_q)
            RECOVER: begin
                if (!req) begin
                    state_d = HOLD;
                end else if (cnt_q == REC_LAST) begin
                    state_d = READY;
                    seq_inc = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            READY: begin
                if (!req) begin
                    state_d = HOLD;
                end
            end
            default: begin
                // HOLD, and the unused encoding which behaves as HOLD
                state_d = HOLD;
                if (cnt_q == LOW_LAST) begin
                    if (req) begin
                        state_d = RECOVER;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase

        // Soft pulse overrides everything, including a completing recovery
        if (soft_pulse) begin
            state_d = HOLD;
            cnt_d   = '0;
            seq_inc = 1'b0;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Combinational read mux
    always_comb begin
        bus.readdata = 32'd0;
        case (bus.address)
            2'd0:    bus.readdata = {29'd0, lcd_ready, state_q};
            2'd2:    bus.readdata = {24'd0, seq_count};
            default: bus.readdata = 32'd0;
        endcase
    end

endmodule
